// File: rtl/fifo_rd_burst_pkg.sv
// Shared state encoding and burst sizing for the FIFO read-side burst master.
// Types and constants only: no latency, no flow control.
package fifo_rd_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int unsigned DEF_BURST_LEN      = 16;
  localparam int unsigned DEF_BYTES_PER_BEAT = 4;
  localparam int unsigned BURST_BYTES        = DEF_BURST_LEN * DEF_BYTES_PER_BEAT;

  function automatic int unsigned burst_bytes(input int unsigned len, input int unsigned bpb);
    return len * bpb;
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Ring address generator: advances by the finished burst's byte length, one-cycle update.
// Wraps to ADDR_BASE when a full burst from the next address would pass ADDR_LIMIT; no backpressure.
module burst_addr_gen
  import fifo_rd_burst_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter int unsigned             LEN_WIDTH      = 8,
  parameter int unsigned             BYTES_PER_BEAT = 4,
  parameter int unsigned             BURST_SPAN     = BURST_BYTES,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_BASE      = '0,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_LIMIT     = 'h0010_0000
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  advance,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic [ADDR_WIDTH-1:0] burst_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH:0]   next_addr;
  logic                  wrap;

  // One extra bit so the limit compare cannot overflow near the top of the address space.
  assign step      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES_PER_BEAT);
  assign next_addr = {1'b0, burst_addr} + {1'b0, step};
  assign wrap      = (next_addr + (ADDR_WIDTH+1)'(BURST_SPAN)) > {1'b0, ADDR_LIMIT};

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      burst_addr <= ADDR_BASE;
    end else if (advance) begin
      burst_addr <= wrap ? ADDR_BASE : next_addr[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fifo_rd_burst_master.sv
// Pulls fixed-length bursts from an FWFT FIFO; beats pass through with zero added latency.
// Beats stall on data_ready=0 or fifo_empty; one request outstanding, held until burst_req_ready.
module fifo_rd_burst_master
  import fifo_rd_burst_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           CNT_WIDTH      = 11,
  parameter int unsigned           BURST_LEN      = 16,
  parameter int unsigned           LEN_WIDTH      = 8,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           BYTES_PER_BEAT = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE      = 'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = 'h0010_0000
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic [CNT_WIDTH-1:0]  rd_data_count,
  output logic                  fifo_rd_en,
  output logic                  burst_req_valid,
  input  logic                  burst_req_ready,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_last,
  output logic                  busy,
  output logic                  flush_done
);

  localparam int unsigned BURST_SPAN = burst_bytes(BURST_LEN, BYTES_PER_BEAT);

  state_t               state, state_nxt;
  logic                 flush_pending;
  logic                 partial_burst;
  logic [LEN_WIDTH:0]   beats_left;
  logic                 full_ok, part_ok, empty_flush;
  logic                 req_hs, beat_hs, last_hs;

  assign full_ok     = enable && (rd_data_count >= CNT_WIDTH'(BURST_LEN));
  assign part_ok     = flush_pending && (rd_data_count != '0) &&
                       (rd_data_count < CNT_WIDTH'(BURST_LEN));
  assign empty_flush = flush_pending && (rd_data_count == '0);
  assign req_hs      = (state == REQ) && burst_req_ready;
  assign beat_hs     = data_valid && data_ready;
  assign last_hs     = beat_hs && (beats_left == (LEN_WIDTH+1)'(1));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full_ok || part_ok) state_nxt = REQ;
      REQ:     if (burst_req_ready)    state_nxt = DATA;
      DATA:    if (last_hs)            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    burst_req_valid = 1'b0;
    data_valid      = 1'b0;
    data_last       = 1'b0;
    fifo_rd_en      = 1'b0;
    data            = fifo_rd_data;
    busy            = (state != IDLE) || flush_pending;
    if (state == REQ) burst_req_valid = 1'b1;
    if (state == DATA) begin
      data_valid = !fifo_empty;
      data_last  = !fifo_empty && (beats_left == (LEN_WIDTH+1)'(1));
      fifo_rd_en = !fifo_empty && data_ready;
    end
  end

  // Full bursts take priority; a pending flush is only consumed once no full burst is due.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      burst_len     <= '0;
      beats_left    <= '0;
      flush_pending <= 1'b0;
      partial_burst <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      flush_done <= ((state == IDLE) && !full_ok && empty_flush) || (last_hs && partial_burst);

      if ((state == IDLE) && !full_ok && (part_ok || empty_flush)) flush_pending <= 1'b0;
      else if (flush)                                              flush_pending <= 1'b1;

      if (state == IDLE) begin
        if (full_ok) begin
          burst_len     <= LEN_WIDTH'(BURST_LEN - 1);
          partial_burst <= 1'b0;
        end else if (part_ok) begin
          burst_len     <= LEN_WIDTH'(rd_data_count - CNT_WIDTH'(1));
          partial_burst <= 1'b1;
        end
      end

      if (req_hs)       beats_left <= {1'b0, burst_len} + (LEN_WIDTH+1)'(1);
      else if (beat_hs) beats_left <= beats_left - (LEN_WIDTH+1)'(1);
    end
  end

  burst_addr_gen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .BYTES_PER_BEAT(BYTES_PER_BEAT),
    .BURST_SPAN    (BURST_SPAN),
    .ADDR_BASE     (ADDR_BASE),
    .ADDR_LIMIT    (ADDR_LIMIT)
  ) u_addr_gen (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .advance   (last_hs),
    .len       (burst_len),
    .burst_addr(burst_addr)
  );

endmodule

// File: tb/tb_fifo_rd_burst_master.sv
// Directed bench for fifo_rd_burst_master with a queue-based FWFT FIFO model.
// Ring limit shrunk to 0x100 so address wrap is reachable in a few bursts.
module tb_fifo_rd_burst_master;

  localparam int DW = 32;
  localparam int CW = 11;
  localparam int LW = 8;
  localparam int AW = 32;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          enable, flush, fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_rd_data, data;
  logic [CW-1:0] rd_data_count;
  logic          burst_req_valid, burst_req_ready;
  logic [AW-1:0] burst_addr;
  logic [LW-1:0] burst_len;
  logic          data_valid, data_ready, data_last, busy, flush_done;

  fifo_rd_burst_master #(.ADDR_LIMIT(32'h0000_0100)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .rd_data_count(rd_data_count),
    .fifo_rd_en(fifo_rd_en), .burst_req_valid(burst_req_valid), .burst_req_ready(burst_req_ready),
    .burst_addr(burst_addr), .burst_len(burst_len), .data_valid(data_valid),
    .data_ready(data_ready), .data(data), .data_last(data_last), .busy(busy),
    .flush_done(flush_done)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] beats_q[$];
  logic [AW-1:0] req_addr[$];
  logic [LW-1:0] req_len[$];
  int            last_idx[$];
  int            fd_cyc[$];
  int            cyc, n_pops, n_beats, bad_pop, stall_change, req_unstable, last_beat_cyc;
  logic          prev_stall, prev_req_wait;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic [LW-1:0] prev_len;
  logic [DW-1:0] next_word = 32'hD000_0000;

  function automatic logic [AW-1:0] qa(input int i);
    return (i < req_addr.size()) ? req_addr[i] : 'x;
  endfunction
  function automatic logic [LW-1:0] ql(input int i);
    return (i < req_len.size()) ? req_len[i] : 'x;
  endfunction
  function automatic int qi(input int i);
    return (i < last_idx.size()) ? last_idx[i] : -1;
  endfunction
  function automatic int qf(input int i);
    return (i < fd_cyc.size()) ? fd_cyc[i] : -1;
  endfunction
  function automatic int data_errs();
    int bad = 0;
    for (int i = 0; i < beats_q.size(); i++)
      if (i >= exp_q.size() || beats_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic update_fifo();
    fifo_empty    = (fq.size() == 0);
    fifo_rd_data  = (fq.size() != 0) ? fq[0] : '0;
    rd_data_count = CW'(fq.size());
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      exp_q.push_back(next_word);
      next_word = next_word + 1;
    end
    update_fifo();
  endtask

  task automatic clear_rec();
    beats_q.delete(); req_addr.delete(); req_len.delete(); last_idx.delete(); fd_cyc.delete();
    exp_q.delete();
    cyc = 0; n_pops = 0; n_beats = 0; bad_pop = 0; stall_change = 0; req_unstable = 0;
    last_beat_cyc = -1; prev_stall = 1'b0; prev_req_wait = 1'b0;
  endtask

  // Observe at the falling edge, then apply the pop right after the rising edge.
  task automatic tick();
    logic s_pop;
    @(negedge rd_clk);
    s_pop = fifo_rd_en;
    if (burst_req_valid && burst_req_ready) begin
      req_addr.push_back(burst_addr);
      req_len.push_back(burst_len);
    end
    if (prev_req_wait && burst_req_valid && (burst_addr !== prev_addr || burst_len !== prev_len))
      req_unstable++;
    prev_req_wait = burst_req_valid && !burst_req_ready;
    prev_addr = burst_addr;
    prev_len  = burst_len;
    if (data_valid && data_ready) begin
      beats_q.push_back(data);
      n_beats++;
      if (data_last) begin
        last_idx.push_back(n_beats);
        last_beat_cyc = cyc;
      end
    end
    if (fifo_rd_en) n_pops++;
    if (fifo_rd_en && !data_ready) bad_pop++;
    if (prev_stall && data !== prev_data) stall_change++;
    prev_stall = data_valid && !data_ready;
    prev_data  = data;
    if (flush_done) fd_cyc.push_back(cyc);
    @(posedge rd_clk);
    #1;
    if (s_pop && fq.size() != 0) void'(fq.pop_front());
    update_fifo();
    cyc++;
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    enable = 1'b0; flush = 1'b0; data_ready = 1'b1; burst_req_ready = 1'b1;
    fq.delete();
    update_fifo();
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    clear_rec();
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0;
    enable = 1'b0; flush = 1'b0; data_ready = 1'b1; burst_req_ready = 1'b1;
    fq.delete();
    update_fifo();
    #2;
    n_checks++; if (burst_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", burst_req_valid); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL rst_data_valid got %b want 0", data_valid); else n_pass++;
    n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b want 0", fifo_rd_en); else n_pass++;
    n_checks++; if (busy !== 1'b0 || flush_done !== 1'b0) $display("FAIL rst_busy_fd got %b%b want 00", busy, flush_done); else n_pass++;
    n_checks++; if (burst_len !== 8'd0) $display("FAIL rst_len got %0d want 0", burst_len); else n_pass++;
    n_checks++; if (burst_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", burst_addr); else n_pass++;
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    clear_rec();
  endtask

  task automatic test_full_burst();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 15; i++) begin push(1); tick(); end
    repeat (3) tick();
    n_checks++; if (req_addr.size() !== 0) $display("FAIL full_no_req_at_15 got %0d reqs want 0", req_addr.size()); else n_pass++;
    push(1);
    repeat (40) tick();
    n_checks++; if (req_addr.size() !== 1) $display("FAIL full_req_count got %0d want 1", req_addr.size()); else n_pass++;
    n_checks++; if (qa(0) !== 32'h0 || ql(0) !== 8'd15) $display("FAIL full_req got addr %h len %0d want 0/15", qa(0), ql(0)); else n_pass++;
    n_checks++; if (n_beats !== 16 || n_pops !== 16) $display("FAIL full_beats got %0d beats %0d pops want 16/16", n_beats, n_pops); else n_pass++;
    n_checks++; if (last_idx.size() !== 1 || qi(0) !== 16) $display("FAIL full_last got %0d marks first %0d want 1 at 16", last_idx.size(), qi(0)); else n_pass++;
    n_checks++; if (data_errs() !== 0) $display("FAIL full_data got %0d bad beats want 0", data_errs()); else n_pass++;
    n_checks++; if (burst_addr !== 32'h40) $display("FAIL full_next_addr got %h want 40", burst_addr); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    push(16);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      data_ready = (i % 2 == 0);
      tick();
    end
    data_ready = 1'b1;
    n_checks++; if (bad_pop !== 0) $display("FAIL bp_pop_while_stalled got %0d want 0", bad_pop); else n_pass++;
    n_checks++; if (stall_change !== 0) $display("FAIL bp_data_stable got %0d changes want 0", stall_change); else n_pass++;
    n_checks++; if (n_pops !== 16 || n_beats !== 16) $display("FAIL bp_pops got %0d pops %0d beats want 16/16", n_pops, n_beats); else n_pass++;
    n_checks++; if (qi(0) !== 16) $display("FAIL bp_last got %0d want 16", qi(0)); else n_pass++;
    n_checks++; if (data_errs() !== 0) $display("FAIL bp_data got %0d bad beats want 0", data_errs()); else n_pass++;
  endtask

  task automatic test_flush_partial();
    do_reset();
    burst_req_ready = 1'b0;
    enable = 1'b1;
    push(5);
    repeat (3) tick();
    n_checks++; if (burst_req_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fp_idle got req %b busy %b want 0/0", burst_req_valid, busy); else n_pass++;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (4) tick();
    n_checks++; if (burst_req_valid !== 1'b1 || burst_len !== 8'd4) $display("FAIL fp_req_held got valid %b len %0d want 1/4", burst_req_valid, burst_len); else n_pass++;
    burst_req_ready = 1'b1;
    repeat (30) tick();
    n_checks++; if (req_len.size() !== 1 || ql(0) !== 8'd4) $display("FAIL fp_req got %0d reqs len %0d want 1/4", req_len.size(), ql(0)); else n_pass++;
    n_checks++; if (req_unstable !== 0) $display("FAIL fp_req_stable got %0d changes want 0", req_unstable); else n_pass++;
    n_checks++; if (n_beats !== 5 || qi(0) !== 5) $display("FAIL fp_beats got %0d last %0d want 5/5", n_beats, qi(0)); else n_pass++;
    n_checks++; if (fd_cyc.size() !== 1 || qf(0) !== last_beat_cyc + 1) $display("FAIL fp_flush_done got %0d pulses at %0d want 1 at %0d", fd_cyc.size(), qf(0), last_beat_cyc + 1); else n_pass++;
    n_checks++; if (fq.size() !== 0 || busy !== 1'b0) $display("FAIL fp_drained got %0d words busy %b want 0/0", fq.size(), busy); else n_pass++;
    n_checks++; if (data_errs() !== 0) $display("FAIL fp_data got %0d bad beats want 0", data_errs()); else n_pass++;
  endtask

  task automatic test_flush_empty();
    int fcyc;
    do_reset();
    enable = 1'b1;
    fcyc = cyc;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (10) tick();
    // pending is set by the pulse edge, then flush_done is registered one IDLE cycle later
    n_checks++; if (req_addr.size() !== 0) $display("FAIL fe_no_req got %0d want 0", req_addr.size()); else n_pass++;
    n_checks++; if (fd_cyc.size() !== 1 || qf(0) !== fcyc + 2) $display("FAIL fe_flush_done got %0d pulses at %0d want 1 at %0d", fd_cyc.size(), qf(0), fcyc + 2); else n_pass++;
  endtask

  task automatic test_flush_during_full();
    do_reset();
    push(20);
    enable = 1'b1;
    for (int i = 0; i < 40 && n_beats < 3; i++) tick();
    n_checks++; if (n_beats !== 3) $display("FAIL fd_wait_beats got %0d want 3", n_beats); else n_pass++;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (60) tick();
    n_checks++; if (req_len.size() !== 2) $display("FAIL fd_req_count got %0d want 2", req_len.size()); else n_pass++;
    n_checks++; if (ql(0) !== 8'd15 || qa(0) !== 32'h0) $display("FAIL fd_req0 got len %0d addr %h want 15/0", ql(0), qa(0)); else n_pass++;
    n_checks++; if (ql(1) !== 8'd3 || qa(1) !== 32'h40) $display("FAIL fd_req1 got len %0d addr %h want 3/40", ql(1), qa(1)); else n_pass++;
    n_checks++; if (n_beats !== 20 || qi(0) !== 16 || qi(1) !== 20) $display("FAIL fd_beats got %0d last %0d,%0d want 20/16,20", n_beats, qi(0), qi(1)); else n_pass++;
    n_checks++; if (fd_cyc.size() !== 1 || qf(0) !== last_beat_cyc + 1) $display("FAIL fd_flush_done got %0d pulses at %0d want 1 at %0d", fd_cyc.size(), qf(0), last_beat_cyc + 1); else n_pass++;
    n_checks++; if (data_errs() !== 0 || fq.size() !== 0) $display("FAIL fd_data got %0d bad %0d left want 0/0", data_errs(), fq.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wa[5];
    wa = '{32'h00, 32'h40, 32'h80, 32'hC0, 32'h00};
    do_reset();
    push(80);
    enable = 1'b1;
    repeat (150) tick();
    n_checks++; if (req_addr.size() !== 5) $display("FAIL wrap_req_count got %0d want 5", req_addr.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (qa(i) !== wa[i]) $display("FAIL wrap_addr%0d got %h want %h", i, qa(i), wa[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push(32);
    enable = 1'b1;
    for (int i = 0; i < 80 && n_beats < 23; i++) tick();
    n_checks++; if (n_beats !== 23 || burst_addr !== 32'h40) $display("FAIL mr_setup got %0d beats addr %h want 23/40", n_beats, burst_addr); else n_pass++;
    rd_rst_n = 1'b0;
    fq.delete();
    update_fifo();
    #2;
    n_checks++; if (data_valid !== 1'b0 || data_last !== 1'b0 || fifo_rd_en !== 1'b0) $display("FAIL mr_data got valid %b last %b rd_en %b want 000", data_valid, data_last, fifo_rd_en); else n_pass++;
    n_checks++; if (burst_req_valid !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) $display("FAIL mr_ctrl got req %b busy %b fd %b want 000", burst_req_valid, busy, flush_done); else n_pass++;
    n_checks++; if (burst_addr !== 32'h0 || burst_len !== 8'd0) $display("FAIL mr_regs got addr %h len %0d want 0/0", burst_addr, burst_len); else n_pass++;
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0 || burst_req_valid !== 1'b0) $display("FAIL mr_idle got busy %b req %b want 0/0", busy, burst_req_valid); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_during_full();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
